// File: rtl/clk_div_multi.sv
// N-channel programmable clock divider: per-channel period, duty cycle and tick strobe,
// with config updates applied only at period boundaries and a shared phase-align input.
module clk_div_multi #(
  parameter int               N_CH       = 4,
  parameter int               WIDTH      = 32,
  parameter logic [WIDTH-1:0] RST_PERIOD = WIDTH'(1),
  parameter logic [WIDTH-1:0] RST_HIGH   = WIDTH'(1),
  localparam int              CH_W       = (N_CH > 1) ? $clog2(N_CH) : 1
) (
  input  logic             basys_clock,
  input  logic             reset_n,
  input  logic [N_CH-1:0]  enable,
  input  logic             sync_in,
  input  logic             cfg_valid,
  output logic             cfg_ready,
  input  logic [CH_W-1:0]  cfg_ch,
  input  logic [WIDTH-1:0] cfg_period,
  input  logic [WIDTH-1:0] cfg_high,
  output logic [N_CH-1:0]  clk_out,
  output logic [N_CH-1:0]  tick
);

  logic [WIDTH-1:0] cnt_r    [N_CH];
  logic [WIDTH-1:0] p_act_r  [N_CH];
  logic [WIDTH-1:0] h_act_r  [N_CH];
  logic [WIDTH-1:0] p_pend_r [N_CH];
  logic [WIDTH-1:0] h_pend_r [N_CH];
  logic [N_CH-1:0]  pend_r;
  logic [N_CH-1:0]  clk_out_r;
  logic [N_CH-1:0]  tick_r;

  logic [WIDTH-1:0] cnt_nxt_s [N_CH];
  logic [WIDTH-1:0] p_nxt_s   [N_CH];
  logic [WIDTH-1:0] h_nxt_s   [N_CH];
  logic [N_CH-1:0]  ch_hit_s;
  logic [N_CH-1:0]  accept_s;
  logic [N_CH-1:0]  restart_s;
  logic [N_CH-1:0]  apply_s;
  logic [N_CH-1:0]  clk_nxt_s;
  logic [N_CH-1:0]  tick_nxt_s;

  // Decode the addressed channel; out-of-range channel numbers match nothing.
  always_comb begin
    for (int i = 0; i < N_CH; i++) begin
      ch_hit_s[i] = (cfg_ch == CH_W'(i));
    end
  end

  assign cfg_ready = reset_n & ~|(pend_r & ch_hit_s);
  assign accept_s  = ch_hit_s & {N_CH{cfg_valid & cfg_ready}};

  // Per-channel next count, boundary detection, config apply and output values.
  always_comb begin
    for (int i = 0; i < N_CH; i++) begin
      if (enable[i] && (sync_in || (cnt_r[i] == p_act_r[i]))) begin
        restart_s[i] = 1'b1;
      end else begin
        restart_s[i] = 1'b0;
      end

      // Pending settings swap in only where no partial period can be produced.
      apply_s[i] = pend_r[i] & (restart_s[i] | ~enable[i]);

      if (apply_s[i]) begin
        p_nxt_s[i] = p_pend_r[i];
        h_nxt_s[i] = h_pend_r[i];
      end else begin
        p_nxt_s[i] = p_act_r[i];
        h_nxt_s[i] = h_act_r[i];
      end

      if (!enable[i]) begin
        cnt_nxt_s[i] = p_nxt_s[i];
      end else if (restart_s[i]) begin
        cnt_nxt_s[i] = '0;
      end else begin
        cnt_nxt_s[i] = cnt_r[i] + WIDTH'(1);
      end

      clk_nxt_s[i]  = enable[i] & (cnt_nxt_s[i] < h_nxt_s[i]);
      tick_nxt_s[i] = enable[i] & (cnt_nxt_s[i] == '0);
    end
  end

  // Channel state, shadow config and registered outputs.
  always_ff @(posedge basys_clock) begin
    if (!reset_n) begin
      for (int i = 0; i < N_CH; i++) begin
        cnt_r[i]    <= RST_PERIOD;
        p_act_r[i]  <= RST_PERIOD;
        h_act_r[i]  <= RST_HIGH;
        p_pend_r[i] <= '0;
        h_pend_r[i] <= '0;
      end
      pend_r    <= '0;
      clk_out_r <= '0;
      tick_r    <= '0;
    end else begin
      for (int i = 0; i < N_CH; i++) begin
        cnt_r[i]   <= cnt_nxt_s[i];
        p_act_r[i] <= p_nxt_s[i];
        h_act_r[i] <= h_nxt_s[i];
        if (accept_s[i]) begin
          p_pend_r[i] <= cfg_period;
          h_pend_r[i] <= cfg_high;
          pend_r[i]   <= 1'b1;
        end else if (apply_s[i]) begin
          pend_r[i]   <= 1'b0;
        end else begin
          pend_r[i]   <= pend_r[i];
        end
      end
      clk_out_r <= clk_nxt_s;
      tick_r    <= tick_nxt_s;
    end
  end

  assign clk_out = clk_out_r;
  assign tick    = tick_r;

endmodule

// File: tb/tb_clk_div_multi.sv
// Scoreboard bench for clk_div_multi: a period/position model predicts every output sample
// and cfg_ready; a negedge monitor pops predictions and compares them with the DUT.
module tb_clk_div_multi;
  localparam int N_CH  = 4;
  localparam int WIDTH = 32;

  logic             basys_clock = 1'b0;
  logic             reset_n     = 1'b0;
  logic [N_CH-1:0]  enable      = '0;
  logic             sync_in     = 1'b0;
  logic             cfg_valid   = 1'b0;
  logic             cfg_ready;
  logic [1:0]       cfg_ch      = 2'd0;
  logic [WIDTH-1:0] cfg_period  = '0;
  logic [WIDTH-1:0] cfg_high    = '0;
  logic [N_CH-1:0]  clk_out;
  logic [N_CH-1:0]  tick;

  int checks = 0;
  int errors = 0;

  always #5 basys_clock = ~basys_clock;

  clk_div_multi #(.N_CH(N_CH), .WIDTH(WIDTH)) dut (
    .basys_clock(basys_clock), .reset_n(reset_n), .enable(enable), .sync_in(sync_in),
    .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .cfg_ch(cfg_ch),
    .cfg_period(cfg_period), .cfg_high(cfg_high), .clk_out(clk_out), .tick(tick)
  );

  typedef struct packed {
    logic [N_CH-1:0] clk;
    logic [N_CH-1:0] tk;
  } exp_t;
  exp_t exp_q[$];

  // Model: each channel is a period length, a high length and a position inside the period.
  longint m_len[N_CH], m_high[N_CH], m_pos[N_CH], m_plen[N_CH], m_phigh[N_CH];
  bit     m_pend[N_CH];
  logic [N_CH-1:0] en_v = '0;

  task automatic drive(input logic rst, input logic sy, input logic v,
                       input int ch, input longint p, input longint h);
    exp_t   e;
    bit     rdy;
    longint np;
    @(negedge basys_clock);
    #1;
    reset_n = rst; enable = en_v; sync_in = sy; cfg_valid = v;
    cfg_ch = ch[1:0]; cfg_period = p[31:0]; cfg_high = h[31:0];
    #1;
    rdy = rst && ((ch >= N_CH) || !m_pend[ch]);
    checks++;
    if (cfg_ready !== rdy) begin
      errors++;
      $display("FAIL cfg_ready t=%0t ch=%0d: got %b expected %b", $time, ch, cfg_ready, rdy);
    end
    e = '0;
    for (int c = 0; c < N_CH; c++) begin
      if (!rst) begin
        m_len[c] = 2; m_high[c] = 1; m_pos[c] = 1; m_pend[c] = 0;
      end else begin
        np = m_pos[c];
        if (en_v[c]) np = sy ? 0 : (m_pos[c] + 1) % m_len[c];
        if (m_pend[c] && (!en_v[c] || np == 0)) begin
          m_len[c] = m_plen[c]; m_high[c] = m_phigh[c]; m_pend[c] = 0;
        end
        if (!en_v[c]) np = m_len[c] - 1;
        m_pos[c] = np;
        e.clk[c] = en_v[c] && (np < m_high[c]);
        e.tk[c]  = en_v[c] && (np == 0);
        if (v && rdy && ch == c) begin
          m_pend[c] = 1; m_plen[c] = p + 1; m_phigh[c] = h;
        end
      end
    end
    exp_q.push_back(e);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b1, 1'b0, 1'b0, 0, 0, 0);
  endtask

  task automatic wr(input int ch, input longint p, input longint h);
    drive(1'b1, 1'b0, 1'b1, ch, p, h);
  endtask

  // Monitor: every sample after an edge is matched against the oldest prediction.
  always @(negedge basys_clock) begin
    exp_t e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      checks++;
      if (clk_out !== e.clk || tick !== e.tk) begin
        errors++;
        $display("FAIL outputs t=%0t: clk_out=%b tick=%b expected clk_out=%b tick=%b",
                 $time, clk_out, tick, e.clk, e.tk);
      end
    end
  end

  initial begin
    int r;
    longint h;
    for (int i = 0; i < 3; i++) drive(1'b0, 1'b0, 1'b0, 0, 0, 0);
    idle(2);
    en_v = '1;
    idle(10);
    // ch0 lengthens from period 2 to 10 at the next wrap
    wr(0, 9, 3);
    idle(25);
    // ch1 duty extremes
    wr(1, 4, 0); idle(12);
    wr(1, 4, 5); idle(12);
    wr(1, 4, 7); idle(12);
    // ch2/ch3 phase alignment through sync_in
    wr(2, 6, 3); wr(3, 3, 2); idle(12);
    drive(1'b1, 1'b1, 1'b0, 0, 0, 0);
    idle(15);
    // write in the exact wrap cycle, then a blocked second write
    for (int k = 0; k < 30 && m_pos[2] != m_len[2] - 1; k++) idle(1);
    wr(2, 8, 4);
    wr(2, 2, 1);
    idle(25);
    // disable mid-period, reconfigure, re-enable, then a reset pulse mid-period
    for (int k = 0; k < 30 && m_pos[0] != 4; k++) idle(1);
    en_v[0] = 1'b0;
    wr(0, 2, 1);
    idle(2);
    en_v[0] = 1'b1;
    idle(10);
    drive(1'b0, 1'b0, 1'b1, 1, 5, 2);
    idle(8);
    // randomized traffic
    for (int n = 0; n < 1500; n++) begin
      if ($urandom_range(0, 19) == 0) begin
        r = $urandom_range(0, N_CH - 1);
        en_v[r] = ~en_v[r];
      end
      r = $urandom_range(0, 99);
      h = ($urandom_range(0, 9) == 0) ? 64'h0000_0000_FFFF_FFFF : longint'($urandom_range(0, 12));
      if (r < 2) drive(1'b0, 1'b0, 1'b0, 0, 0, 0);
      else drive(1'b1, r < 6, r >= 60, $urandom_range(0, N_CH - 1), $urandom_range(0, 10), h);
    end
    @(negedge basys_clock);
    #2;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d predictions left, expected 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
